// File: rtl/e_mdu.sv
// e_mdu: Execute-stage multiply/divide unit holding the HI/LO registers
//  clk     in   1   clock, rising edge
//  reset   in   1   synchronous, active-high
//  start   in   1   launch mdu_op this cycle
//  mdu_op  in   3   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//  rs_val  in   32  multiplicand/dividend, MTHI/MTLO source
//  rt_val  in   32  multiplier/divisor
//  busy    out  1   operation in flight
//  hi      out  32  HI register
//  lo      out  32  LO register
module e_mdu #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    op_q;
   logic [31:0]   a_q, b_q;
   logic          is_mul, is_sgn;
   logic [63:0]   prod;
   logic [31:0]   abs_a, abs_b, dvd, dvs, uq, ur, quot, rem;
   assign is_mul = op_q == 3'd1 || op_q == 3'd2;
   assign is_sgn = op_q == 3'd1 || op_q == 3'd3;
   // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve MULT and MULTU.
   assign prod = {{32{is_sgn & a_q[31]}}, a_q} * {{32{is_sgn & b_q[31]}}, b_q};
   // Signed division runs on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
   assign abs_a = a_q[31] ? -a_q : a_q;
   assign abs_b = b_q[31] ? -b_q : b_q;
   assign dvd   = is_sgn ? abs_a : a_q;
   assign dvs   = b_q == 32'd0 ? 32'd1 : (is_sgn ? abs_b : b_q);
   assign uq    = dvd / dvs;
   assign ur    = dvd % dvs;
   assign quot  = is_sgn && (a_q[31] ^ b_q[31]) ? -uq : uq;
   assign rem   = is_sgn && a_q[31] ? -ur : ur;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         op_q  <= 3'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else if (state == RUN) begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (is_mul) begin
               hi <= prod[63:32];
               lo <= prod[31:0];
            end else if (b_q != 32'd0) begin
               hi <= rem;
               lo <= quot;
            end
         end
      end else if (start) begin
         if (mdu_op inside {[3'd1:3'd4]}) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= mdu_op;
            a_q   <= rs_val;
            b_q   <= rt_val;
            cnt   <= mdu_op <= 3'd2 ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
         end else if (mdu_op == 3'd5)
            hi <= rs_val;
         else if (mdu_op == 3'd6)
            lo <= rs_val;
      end
   end
endmodule
